// File: rtl/dffram_stream_pkg.sv
// -----------------------------------------------------------------------------
// dffram_stream_pkg
// Shared definitions for the DFFRAM read-side streaming engine.
//   stream_state_t     : controller states (IDLE / RUN / DRAIN)
//   RD_LATENCY         : wrapper read latency in cycles. The single-bit in-flight
//                        tracking in the reader assumes exactly one cycle.
//   fifo_count_width() : width of an occupancy counter able to hold 0..depth.
// -----------------------------------------------------------------------------
package dffram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stream_state_t;

  localparam int RD_LATENCY = 1;

  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Small synchronous first-word-fall-through FIFO used as the output buffer of
// the stream reader. The head entry is visible on pop_data without a read
// cycle, so the stream can move one word per clock.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : drop all entries (takes priority over push/pop)
//   push, push_data   : write one entry (caller guarantees space)
//   pop               : remove head entry (caller guarantees not empty)
//   pop_data          : head entry
//   count             : registered occupancy, 0..DEPTH
//   empty             : count == 0
// -----------------------------------------------------------------------------
module stream_fifo
  import dffram_stream_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fifo_count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Storage is reset so the head word (and therefore the stream data/last
  // outputs) reads as zero straight out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (push && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;
  assign empty    = (count_reg == '0);

endmodule

// File: rtl/dffram_stream_reader.sv
// -----------------------------------------------------------------------------
// dffram_stream_reader
// Walks a contiguous, wrap-around address range on the DFFRAM wrapper read
// port (port 1) and presents the words on a valid/ready stream with a last
// flag. Reads are only issued when the output FIFO is guaranteed to have room
// for the returning word, so backpressure never drops or repeats a read.
//
// Optional feature: define STREAM_READER_ABORT_EN to add the abort input,
// which cancels a running command, flushes buffered words and pulses done.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : command strobe, honoured only in IDLE
//   base_addr, length  : command range (length 0..2^ADDR_WIDTH words)
//   busy               : command in progress (RUN or DRAIN)
//   done               : one-cycle completion pulse
//   csb1, addr1        : wrapper read chip select (active low) and address
//   dout1              : wrapper read data, valid one cycle after the read
//   out_valid/ready    : stream handshake
//   out_data, out_last : stream word and end-of-command marker
//   abort              : (STREAM_READER_ABORT_EN only) cancel command
// -----------------------------------------------------------------------------
module dffram_stream_reader
  import dffram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef STREAM_READER_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int CNT_W = fifo_count_width(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  stream_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [ADDR_WIDTH:0]   len_reg, len_next;
  logic [ADDR_WIDTH:0]   issued_reg, issued_next;
  logic                  inflight_reg, inflight_next;
  logic                  inflight_last_reg, inflight_last_next;
  logic [ADDR_WIDTH-1:0] last_addr_reg, last_addr_next;
  logic                  zero_done_reg, zero_done_next;
  logic                  abort_done_reg, abort_done_next;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_pop_data;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [CNT_W:0]        occupancy;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  issue;
  logic                  complete;
  logic                  abort_hit;

  // ---------------------------------------------------------------------------
  // Issue / completion decode. Everything here depends on registered state
  // only, so out_ready has no combinational path to csb1/addr1.
  // ---------------------------------------------------------------------------
  // Credit counts the registered FIFO occupancy plus the word still coming
  // back from the RAM; a pop in the same cycle is deliberately not credited.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
  assign cur_addr  = base_reg + issued_reg[ADDR_WIDTH-1:0];
  assign issue     = (state_reg == RUN) && (occupancy < DEPTH_LIM);
  assign complete  = (state_reg == DRAIN) && !inflight_reg && fifo_empty;

`ifdef STREAM_READER_ABORT_EN
  // An abort landing in the natural completion cycle is a no-op, so the
  // command never produces two done pulses.
  assign abort_hit = abort && (state_reg != IDLE) && !complete;
`else
  assign abort_hit = 1'b0;
`endif

  assign csb1  = !issue;
  assign addr1 = issue ? cur_addr : last_addr_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = complete || zero_done_reg || abort_done_reg;

  // ---------------------------------------------------------------------------
  // Output buffer. The captured word is pushed unconditionally; the credit
  // check above guarantees a free slot.
  // ---------------------------------------------------------------------------
  assign fifo_push = inflight_reg && !abort_hit;
  assign fifo_pop  = out_valid && out_ready;

  stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_hit),
    .push      (fifo_push),
    .push_data ({inflight_last_reg, dout1}),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = fifo_pop_data[DATA_WIDTH];
  assign out_data  = fifo_pop_data[DATA_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Controller: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    base_next          = base_reg;
    len_next           = len_reg;
    issued_next        = issued_reg;
    inflight_next      = 1'b0;   // a read is in flight for exactly one cycle
    inflight_last_next = 1'b0;
    last_addr_next     = last_addr_reg;
    zero_done_next     = 1'b0;
    abort_done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next   = base_addr;
          len_next    = length;
          issued_next = '0;
          if (length == '0) begin
            zero_done_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (issue) begin
          inflight_next      = 1'b1;
          inflight_last_next = (issued_reg == (len_reg - LEN_ONE));
          issued_next        = issued_reg + LEN_ONE;
          last_addr_next     = cur_addr;
          if ((issued_reg + LEN_ONE) == len_reg) begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (complete) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort wins over everything: the word returning next cycle is dropped
    // by clearing the in-flight flag, and the FIFO is flushed alongside.
    if (abort_hit) begin
      state_next         = IDLE;
      inflight_next      = 1'b0;
      inflight_last_next = 1'b0;
      abort_done_next    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      base_reg          <= '0;
      len_reg           <= '0;
      issued_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      last_addr_reg     <= '0;
      zero_done_reg     <= 1'b0;
      abort_done_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      base_reg          <= base_next;
      len_reg           <= len_next;
      issued_reg        <= issued_next;
      inflight_reg      <= inflight_next;
      inflight_last_reg <= inflight_last_next;
      last_addr_reg     <= last_addr_next;
      zero_done_reg     <= zero_done_next;
      abort_done_reg    <= abort_done_next;
    end
  end

endmodule
